// File: rtl/idli_pkg.sv
// Shared types and constants for the idli core, including the SQI memory controller.
package idli_pkg;

   typedef enum logic {
      SQI_IO_MODE_OUT = 1'b0,
      SQI_IO_MODE_IN  = 1'b1
   } sqi_io_mode_t;

   typedef enum logic [2:0] {
      INIT  = 3'd0,
      DESEL = 3'd1,
      IDLE  = 3'd2,
      CMD   = 3'd3,
      ADDR  = 3'd4,
      DUMMY = 3'd5,
      DATA  = 3'd6
   } sqi_state_t;

   localparam logic [7:0] SQI_CMD_READ  = 8'h03;
   localparam logic [7:0] SQI_CMD_WRITE = 8'h02;
   localparam logic [7:0] SQI_CMD_EQIO  = 8'h38;

   // Word address to 24-bit byte address; the top bit of the word address never carries.
   function automatic logic [23:0] sqi_byte_addr(input logic [15:0] word_addr);
      return {7'b000_0000, word_addr, 1'b0};
   endfunction

endpackage

// File: rtl/idli_sqi_shift_m.sv
// 32-bit parallel-load shift register feeding the SQI data pins one nibble (or one bit)
// per beat while collecting returned nibbles at the low end.
module idli_sqi_shift_m (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        shift,
   input  logic        bit_mode,
   input  logic        mute,
   input  logic [31:0] load_val,
   input  logic [3:0]  rx_nibble,
   output logic [3:0]  tx_nibble,
   output logic [11:0] tail
);

   logic [31:0] q_r;
   logic [31:0] q_s;
   logic [31:0] src_s;
   logic [3:0]  tx_r;
   logic [3:0]  tx_s;

   // The head of the source word goes to the pins, the remainder moves up one slot.
   always_comb begin
      src_s = load ? load_val : q_r;
      if (bit_mode) begin
         q_s  = {src_s[30:0], 1'b0};
         tx_s = {3'b000, src_s[31]};
      end else begin
         q_s  = {src_s[27:0], (load ? 4'h0 : rx_nibble)};
         tx_s = src_s[31:28];
      end
      if (mute) begin
         tx_s = 4'h0;
      end else begin
         tx_s = tx_s;
      end
   end

   // Register update, only on beat boundaries.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_r  <= 32'h0000_0000;
         tx_r <= 4'h0;
      end else if (load || shift) begin
         q_r  <= q_s;
         tx_r <= tx_s;
      end
   end

   assign tx_nibble = tx_r;
   assign tail      = q_r[11:0];

endmodule

// File: rtl/idli_sqi_ctrl_m.sv
// SQI controller for a 23LC1024-style serial SRAM: quad-mode entry after reset,
// then one 16-bit word read or write per accepted request.
module idli_sqi_ctrl_m
   import idli_pkg::*;
#(
   parameter logic [7:0] CMD_READ  = SQI_CMD_READ,
   parameter logic [7:0] CMD_WRITE = SQI_CMD_WRITE,
   parameter logic [7:0] CMD_EQIO  = SQI_CMD_EQIO
) (
   input  logic         i_sqi_gck,
   input  logic         i_sqi_rst,
   input  logic         i_sqi_req_vld,
   output logic         o_sqi_req_acp,
   input  logic         i_sqi_req_wr,
   input  logic [15:0]  i_sqi_req_addr,
   input  logic [15:0]  i_sqi_req_wdata,
   output logic         o_sqi_rsp_vld,
   output logic [15:0]  o_sqi_rsp_data,
   output logic         o_sqi_mem_sck,
   output logic         o_sqi_mem_cs,
   output sqi_io_mode_t o_sqi_mem_io_mode,
   input  logic [3:0]   i_sqi_mem_sio,
   output logic [3:0]   o_sqi_mem_sio
);

   sqi_state_t   state_r, state_s, follow_s;
   logic [3:0]   beat_r, beat_s, last_beat_s;
   logic         phase_r, phase_s;
   logic         wr_r;
   logic [15:0]  wdata_r;
   logic         cs_r, sck_r;
   sqi_io_mode_t io_mode_r, io_mode_s;
   logic         rsp_vld_r, rsp_vld_s;
   logic [15:0]  rsp_data_r, rsp_data_s;
   logic         accept_s, active_s, load_s, shift_s, bit_mode_s, mute_s;
   logic [31:0]  load_val_s;
   logic [11:0]  tail_s;

   assign accept_s = (state_r == IDLE) && i_sqi_req_vld;

   // Length and successor of each pin-active transaction phase.
   always_comb begin
      last_beat_s = 4'd0;
      follow_s    = DESEL;
      case (state_r)
         CMD:     begin last_beat_s = 4'd1; follow_s = ADDR;                     end
         ADDR:    begin last_beat_s = 4'd5; follow_s = wr_r ? DATA : DUMMY;      end
         DUMMY:   begin last_beat_s = 4'd1; follow_s = DATA;                     end
         DATA:    begin last_beat_s = 4'd3; follow_s = DESEL;                    end
         default: begin last_beat_s = 4'd0; follow_s = DESEL;                    end
      endcase
   end

   // Next state, beat/phase sequencing and shift-register control.
   always_comb begin
      state_s    = state_r;
      beat_s     = beat_r;
      phase_s    = ~phase_r;
      load_s     = 1'b0;
      shift_s    = 1'b0;
      bit_mode_s = 1'b0;
      load_val_s = {CMD_EQIO, 24'h00_0000};
      case (state_r)
         INIT: begin
            bit_mode_s = 1'b1;
            // beat 4'hF is the idle cycle straight out of reset; it loads the opcode.
            if (phase_r && (beat_r == 4'd7)) begin
               state_s = DESEL;
               beat_s  = 4'd0;
               shift_s = 1'b1;
            end else if (phase_r) begin
               beat_s  = beat_r + 4'd1;
               load_s  = (beat_r == 4'hF);
               shift_s = (beat_r != 4'hF);
            end else begin
               beat_s  = beat_r;
            end
         end
         DESEL: begin
            if (phase_r) begin
               state_s = IDLE;
            end else begin
               state_s = DESEL;
            end
         end
         IDLE: begin
            phase_s = 1'b0;
            if (accept_s) begin
               state_s    = CMD;
               beat_s     = 4'd0;
               load_s     = 1'b1;
               load_val_s = {(i_sqi_req_wr ? CMD_WRITE : CMD_READ), sqi_byte_addr(i_sqi_req_addr)};
            end else begin
               state_s    = IDLE;
            end
         end
         CMD, ADDR, DUMMY, DATA: begin
            shift_s = phase_r;
            if (phase_r && (beat_r == last_beat_s)) begin
               state_s = follow_s;
               beat_s  = 4'd0;
            end else if (phase_r) begin
               beat_s  = beat_r + 4'd1;
            end else begin
               beat_s  = beat_r;
            end
            if ((state_r == ADDR) && (state_s == DATA)) begin
               load_s     = 1'b1;
               shift_s    = 1'b0;
               load_val_s = {wdata_r, 16'h0000};
            end else begin
               load_val_s = load_val_s;
            end
         end
         default: begin
            state_s = DESEL;
            beat_s  = 4'd0;
         end
      endcase
   end

   // Pin and response values for the cycle that follows the current edge.
   always_comb begin
      active_s   = state_s inside {INIT, CMD, ADDR, DUMMY, DATA};
      io_mode_s  = ((state_s == DUMMY) || ((state_s == DATA) && !wr_r)) ? SQI_IO_MODE_IN
                                                                        : SQI_IO_MODE_OUT;
      mute_s     = !active_s || (io_mode_s == SQI_IO_MODE_IN);
      rsp_vld_s  = (state_r == DATA) && (state_s == DESEL);
      rsp_data_s = (rsp_vld_s && !wr_r) ? {tail_s, i_sqi_mem_sio} : 16'h0000;
   end

   // State, request latch and registered pin/response outputs.
   always_ff @(posedge i_sqi_gck) begin
      if (i_sqi_rst) begin
         state_r    <= INIT;
         beat_r     <= 4'hF;
         phase_r    <= 1'b1;
         wr_r       <= 1'b0;
         wdata_r    <= 16'h0000;
         cs_r       <= 1'b1;
         sck_r      <= 1'b0;
         io_mode_r  <= SQI_IO_MODE_OUT;
         rsp_vld_r  <= 1'b0;
         rsp_data_r <= 16'h0000;
      end else begin
         state_r    <= state_s;
         beat_r     <= beat_s;
         phase_r    <= phase_s;
         cs_r       <= !active_s;
         sck_r      <= active_s && phase_s;
         io_mode_r  <= io_mode_s;
         rsp_vld_r  <= rsp_vld_s;
         rsp_data_r <= rsp_data_s;
         if (accept_s) begin
            wr_r    <= i_sqi_req_wr;
            wdata_r <= i_sqi_req_wdata;
         end
      end
   end

   idli_sqi_shift_m u_shift (
      .clk       (i_sqi_gck),
      .rst       (i_sqi_rst),
      .load      (load_s),
      .shift     (shift_s),
      .bit_mode  (bit_mode_s),
      .mute      (mute_s),
      .load_val  (load_val_s),
      .rx_nibble (i_sqi_mem_sio),
      .tx_nibble (o_sqi_mem_sio),
      .tail      (tail_s)
   );

   assign o_sqi_req_acp     = (state_r == IDLE);
   assign o_sqi_rsp_vld     = rsp_vld_r;
   assign o_sqi_rsp_data    = rsp_data_r;
   assign o_sqi_mem_sck     = sck_r;
   assign o_sqi_mem_cs      = cs_r;
   assign o_sqi_mem_io_mode = io_mode_r;

endmodule

// File: tb/tb_idli_sqi_ctrl_m.sv
// Directed bench for idli_sqi_ctrl_m: table of word transactions with hand-computed
// pin nibbles and responses, plus reset, back-to-back and mid-transaction reset sequences.
module tb_idli_sqi_ctrl_m;
   import idli_pkg::*;

   typedef struct packed {
      logic        wr;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] rdata;
      logic [47:0] exp_nib;
      logic [15:0] exp_rsp;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         vld, acp, wr;
   logic [15:0]  addr, wdata;
   logic         rsp_vld;
   logic [15:0]  rsp_data;
   logic         sck, cs;
   sqi_io_mode_t io;
   logic [3:0]   mem_sio, sio;

   int checks   = 0;
   int failures = 0;
   vec_t vecs [6];

   idli_sqi_ctrl_m dut (
      .i_sqi_gck         (clk),
      .i_sqi_rst         (rst),
      .i_sqi_req_vld     (vld),
      .o_sqi_req_acp     (acp),
      .i_sqi_req_wr      (wr),
      .i_sqi_req_addr    (addr),
      .i_sqi_req_wdata   (wdata),
      .o_sqi_rsp_vld     (rsp_vld),
      .o_sqi_rsp_data    (rsp_data),
      .o_sqi_mem_sck     (sck),
      .o_sqi_mem_cs      (cs),
      .o_sqi_mem_io_mode (io),
      .i_sqi_mem_sio     (mem_sio),
      .o_sqi_mem_sio     (sio)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Called at a negedge: one full reset cycle, then the EQIO entry sequence.
   task automatic do_reset();
      int err;
      int nb;
      logic [7:0] bits;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_cs", cs, 1);
      chk("rst_sck", sck, 0);
      chk("rst_io_in", io == SQI_IO_MODE_IN, 0);
      chk("rst_sio", sio, 0);
      chk("rst_acp", acp, 0);
      chk("rst_rsp_vld", rsp_vld, 0);
      chk("rst_rsp_data", rsp_data, 0);
      err = 0; nb = 0; bits = 8'h00;
      for (int k = 1; k <= 18; k++) begin
         @(negedge clk);
         if (k <= 16) begin
            if (cs !== 1'b0) err++;
            if (sck !== 1'((k % 2) == 0)) err++;
            if (sck === 1'b1) begin
               bits = {bits[6:0], sio[0]};
               nb++;
               if (sio[3:1] !== 3'b000) err++;
            end
         end else begin
            if (cs !== 1'b1 || sck !== 1'b0) err++;
         end
         if (acp !== 1'b0 || rsp_vld !== 1'b0 || io != SQI_IO_MODE_OUT) err++;
      end
      @(negedge clk);
      chk("init_seq_errs", err, 0);
      chk("init_beats", nb, 8);
      chk("init_eqio", bits, 8'h38);
      chk("init_acp", acp, 1);
   endtask

   // Called at a negedge; ends at the negedge two cycles after rsp_vld (acp expected).
   task automatic run_txn(input vec_t v, input logic hold, input vec_t nv);
      int n, waited, err, beats, nout;
      logic [47:0] got;
      logic exp_in;
      n = v.wr ? 25 : 29;
      vld = 1'b1; wr = v.wr; addr = v.addr; wdata = v.wdata;
      waited = 0;
      while (acp !== 1'b1 && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      chk("accept_wait", waited, 0);
      if (acp !== 1'b1) return;
      @(negedge clk);
      if (hold) begin
         wr = nv.wr; addr = nv.addr; wdata = nv.wdata;
      end else begin
         vld = 1'b0;
      end
      err = 0; beats = 0; nout = 0; got = 48'h0;
      for (int k = 1; k <= n + 2; k++) begin
         if (k > 1) @(negedge clk);
         mem_sio = 4'h7;
         if (k < n) begin
            exp_in = !v.wr && (k >= 17);
            if (cs !== 1'b0 || rsp_vld !== 1'b0 || acp !== 1'b0 || rsp_data !== 16'h0000) err++;
            if (sck !== 1'((k % 2) == 0)) err++;
            if ((io == SQI_IO_MODE_IN) !== exp_in) err++;
            if (sck === 1'b1) begin
               if (io == SQI_IO_MODE_OUT) begin
                  got = {got[43:0], sio};
                  nout++;
               end else if (sio !== 4'h0) begin
                  err++;
               end
               if (!v.wr && beats >= 10 && beats <= 13)
                  mem_sio = 4'(v.rdata >> (4 * (13 - beats)));
               beats++;
            end
         end else if (k == n) begin
            chk("rsp_vld", rsp_vld, 1);
            chk("rsp_data", rsp_data, v.exp_rsp);
            chk("rsp_cs", cs, 1);
            chk("rsp_io_in", io == SQI_IO_MODE_IN, 0);
         end else if (k == n + 1) begin
            chk("post_rsp_vld", rsp_vld, 0);
            chk("post_acp", acp, 0);
            chk("post_cs", cs, 1);
         end else begin
            chk("next_acp", acp, 1);
            chk("next_cs", cs, 1);
         end
      end
      chk("nibbles", got, v.exp_nib);
      chk("out_nibbles", nout, v.wr ? 12 : 8);
      chk("beats", beats, v.wr ? 14 - 2 : 14);
      chk("seq_errs", err, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{wr: 1'b1, addr: 16'h1234, wdata: 16'hBEEF, rdata: 16'h0000,
                  exp_nib: 48'h0200_2468_BEEF, exp_rsp: 16'h0000};
      vecs[1] = '{wr: 1'b0, addr: 16'h0001, wdata: 16'h0000, rdata: 16'hA5C3,
                  exp_nib: 48'h0000_0300_0002, exp_rsp: 16'hA5C3};
      vecs[2] = '{wr: 1'b0, addr: 16'hFFFF, wdata: 16'h0000, rdata: 16'h1E0F,
                  exp_nib: 48'h0000_0301_FFFE, exp_rsp: 16'h1E0F};
      vecs[3] = '{wr: 1'b1, addr: 16'h0000, wdata: 16'h0001, rdata: 16'h0000,
                  exp_nib: 48'h0200_0000_0001, exp_rsp: 16'h0000};
      vecs[4] = '{wr: 1'b1, addr: 16'hFFFF, wdata: 16'h8000, rdata: 16'h0000,
                  exp_nib: 48'h0201_FFFE_8000, exp_rsp: 16'h0000};
      vecs[5] = '{wr: 1'b0, addr: 16'h8000, wdata: 16'h0000, rdata: 16'hFFFF,
                  exp_nib: 48'h0000_0301_0000, exp_rsp: 16'hFFFF};

      rst = 1'b1; vld = 1'b0; wr = 1'b0; addr = 16'h0; wdata = 16'h0; mem_sio = 4'h0;
      do_reset();

      for (int i = 0; i < 6; i++) run_txn(vecs[i], 1'b0, vecs[i]);

      // Back-to-back: vld stays high, second request accepted on the acp cycle.
      run_txn(vecs[0], 1'b1, vecs[1]);
      run_txn(vecs[1], 1'b0, vecs[1]);

      // Reset in the middle of a read's address phase.
      vld = 1'b1; wr = 1'b0; addr = 16'h0001; wdata = 16'h0000;
      for (int w = 0; w < 100 && acp !== 1'b1; w++) @(negedge clk);
      chk("mr_acp", acp, 1);
      @(negedge clk);
      vld = 1'b0;
      repeat (8) @(negedge clk);
      chk("mr_cs_pre", cs, 0);
      do_reset();
      run_txn(vecs[1], 1'b0, vecs[1]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
